// File: rtl/turbo_ram_pkg.sv
// Shared definitions for the initialised dual-port RAM: clear-sequencer
// states and read-during-write mode encoding.
package turbo_ram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_READY = 2'd2
   } state_t;

   typedef enum logic {
      RDW_READ_FIRST  = 1'b0,
      RDW_WRITE_FIRST = 1'b1
   } rdw_mode_t;

endpackage

// File: rtl/dp_ram_core.sv
// Bare two-port word array with registered read data and a per-port
// read-during-write rule; callers guarantee in-range addresses.
module dp_ram_core
   import turbo_ram_pkg::*;
#(
   parameter int DW        = 2,
   parameter int DEPTH     = 2396,
   parameter int AW        = 12,
   parameter bit RDW_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          enb,
   input  logic          wea,
   input  logic          web,
   input  logic [AW-1:0] addra,
   input  logic [AW-1:0] addrb,
   input  logic [DW-1:0] dia,
   input  logic [DW-1:0] dib,
   output logic [DW-1:0] doa,
   output logic [DW-1:0] dob
);

   localparam rdw_mode_t MODE = rdw_mode_t'(RDW_FIRST);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] doa_q, doa_d;
   logic [DW-1:0] dob_q, dob_d;

   // A read of a word the other port is writing sees the pre-edge contents.
   always_comb begin
      doa_d = doa_q;
      dob_d = dob_q;
      if (ena) doa_d = (wea && MODE == RDW_WRITE_FIRST) ? dia : mem_q[addra];
      if (enb) dob_d = (web && MODE == RDW_WRITE_FIRST) ? dib : mem_q[addrb];
   end

   always_ff @(posedge clk) begin
      if (ena && wea) mem_q[addra] <= dia;
      if (enb && web) mem_q[addrb] <= dib;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         doa_q <= '0;
         dob_q <= '0;
      end else begin
         doa_q <= doa_d;
         dob_q <= dob_d;
      end
   end

   assign doa = doa_q;
   assign dob = dob_q;

endmodule

// File: rtl/dp_ram_init.sv
// Dual-port RAM with a post-reset zeroing sequence, port-A write priority,
// range checking and an optional output register stage.
module dp_ram_init
   import turbo_ram_pkg::*;
#(
   parameter int DW        = 2,
   parameter int DEPTH     = 2396,
   parameter int AW        = 12,
   parameter bit RDW_FIRST = 1'b1,
   parameter bit OUT_REG   = 1'b0,
   parameter bit INIT_CLR  = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          enb,
   input  logic          wea,
   input  logic          web,
   input  logic [AW-1:0] addra,
   input  logic [AW-1:0] addrb,
   input  logic [DW-1:0] dia,
   input  logic [DW-1:0] dib,
   output logic [DW-1:0] doa,
   output logic [DW-1:0] dob,
   output logic          init_busy,
   output logic          collision,
   output logic          oob_err
);

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          coll_q, coll_d;
   logic          oob_q, oob_d;
   logic          zero_a_q, zero_a_d;
   logic          zero_b_q, zero_b_d;

   logic          oob_a, oob_b, clearing;
   logic          wa_ok, wb_ok;
   logic          c_ena, c_wea;
   logic [AW-1:0] c_addra, c_addrb;
   logic [DW-1:0] c_dia, c_doa, c_dob;
   logic [DW-1:0] rd_a, rd_b;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d   = '0;
            state_d = INIT_CLR ? ST_CLEAR : ST_READY;
         end
         ST_CLEAR: begin
            if (cnt_q == AW'(DEPTH - 1)) state_d = ST_READY;
            else                         cnt_d   = cnt_q + AW'(1);
         end
         default: state_d = ST_READY;
      endcase
      busy_d = (state_d != ST_READY);
   end

   assign oob_a    = ({1'b0, addra} >= (AW+1)'(DEPTH));
   assign oob_b    = ({1'b0, addrb} >= (AW+1)'(DEPTH));
   assign clearing = (state_q == ST_CLEAR);

   // Port A wins a same-address double write; B's write is simply dropped.
   assign wa_ok = ena & wea & ~oob_a & ~busy_q;
   assign wb_ok = enb & web & ~oob_b & ~busy_q & ~(wa_ok && addra == addrb);

   assign c_ena   = clearing | ena;
   assign c_wea   = clearing | wa_ok;
   assign c_addra = clearing ? cnt_q : (oob_a ? '0 : addra);
   assign c_dia   = clearing ? '0 : dia;
   assign c_addrb = oob_b ? '0 : addrb;

   always_comb begin
      coll_d   = ena & enb & ~busy_q & (addra == addrb) & (wea | web);
      oob_d    = ~busy_q & ((ena & oob_a) | (enb & oob_b));
      zero_a_d = ena ? (busy_q | oob_a) : zero_a_q;
      zero_b_d = enb ? (busy_q | oob_b) : zero_b_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         busy_q   <= INIT_CLR;
         coll_q   <= 1'b0;
         oob_q    <= 1'b0;
         zero_a_q <= 1'b1;
         zero_b_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         coll_q   <= coll_d;
         oob_q    <= oob_d;
         zero_a_q <= zero_a_d;
         zero_b_q <= zero_b_d;
      end
   end

   dp_ram_core #(
      .DW        (DW),
      .DEPTH     (DEPTH),
      .AW        (AW),
      .RDW_FIRST (RDW_FIRST)
   ) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (c_ena),
      .enb   (enb),
      .wea   (c_wea),
      .web   (wb_ok),
      .addra (c_addra),
      .addrb (c_addrb),
      .dia   (c_dia),
      .dib   (dib),
      .doa   (c_doa),
      .dob   (c_dob)
   );

   // Reads while busy or out of range present zero, held like real data.
   assign rd_a = zero_a_q ? '0 : c_doa;
   assign rd_b = zero_b_q ? '0 : c_dob;

   if (OUT_REG) begin : g_out_reg
      logic          vld_a_q, vld_a_d, vld_b_q, vld_b_d;
      logic [DW-1:0] pa_q, pa_d, pb_q, pb_d;

      always_comb begin
         vld_a_d = ena;
         vld_b_d = enb;
         pa_d    = vld_a_q ? rd_a : pa_q;
         pb_d    = vld_b_q ? rd_b : pb_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_a_q <= 1'b0;
            vld_b_q <= 1'b0;
            pa_q    <= '0;
            pb_q    <= '0;
         end else begin
            vld_a_q <= vld_a_d;
            vld_b_q <= vld_b_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
         end
      end

      assign doa = pa_q;
      assign dob = pb_q;
   end else begin : g_out_direct
      assign doa = rd_a;
      assign dob = rd_b;
   end

   assign init_busy = busy_q;
   assign collision = coll_q;
   assign oob_err   = oob_q;

endmodule

// File: tb/tb_dp_ram_init.sv
// Bench for dp_ram_init: two instances (write-first/unregistered and
// read-first/registered) share stimulus and a word-level reference model.
module tb_dp_ram_init;

   localparam int DW    = 2;
   localparam int DEPTH = 2396;
   localparam int AW    = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          ena = 1'b0, enb = 1'b0, wea = 1'b0, web = 1'b0;
   logic [AW-1:0] addra = '0, addrb = '0;
   logic [DW-1:0] dia = '0, dib = '0;

   logic [DW-1:0] doa1, dob1, doa2, dob2;
   logic          busy1, busy2, coll1, coll2, oob1, oob2;

   int n_asrt = 0;
   int n_fail = 0;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] last1a, last1b, last2a, last2b;

   always #5 clk = ~clk;

   dp_ram_init #(
      .DW(DW), .DEPTH(DEPTH), .AW(AW),
      .RDW_FIRST(1'b1), .OUT_REG(1'b0), .INIT_CLR(1'b1)
   ) u_wf (
      .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
      .doa(doa1), .dob(dob1), .init_busy(busy1), .collision(coll1), .oob_err(oob1)
   );

   dp_ram_init #(
      .DW(DW), .DEPTH(DEPTH), .AW(AW),
      .RDW_FIRST(1'b0), .OUT_REG(1'b1), .INIT_CLR(1'b1)
   ) u_rf (
      .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
      .doa(doa2), .dob(dob2), .init_busy(busy2), .collision(coll2), .oob_err(oob2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_cleared();
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      last1a = '0; last1b = '0; last2a = '0; last2b = '0;
   endtask

   task automatic drive_idle();
      ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;
      addra = '0; addrb = '0; dia = '0; dib = '0;
   endtask

   // One access cycle: drive, let the edge happen, then compare both DUTs.
   task automatic step(input bit ea, input bit eb, input bit wa, input bit wb,
                       input int aa, input int ab, input int da, input int db);
      logic [DW-1:0] old_a, old_b, ra1, ra2, rb1, rb2, exp2a, exp2b;
      bit oa, ob, bdrop, coll, oobx;
      @(negedge clk);
      ena = ea; enb = eb; wea = wa; web = wb;
      addra = AW'(aa); addrb = AW'(ab); dia = DW'(da); dib = DW'(db);
      oa    = (aa >= DEPTH);
      ob    = (ab >= DEPTH);
      old_a = oa ? '0 : mem[oa ? 0 : aa];
      old_b = ob ? '0 : mem[ob ? 0 : ab];
      bdrop = ea && wa && !oa && (aa == ab);
      ra1   = oa ? '0 : (wa ? DW'(da) : old_a);
      ra2   = old_a;
      rb1   = ob ? '0 : ((wb && !bdrop) ? DW'(db) : old_b);
      rb2   = old_b;
      coll  = ea && eb && (aa == ab) && (wa || wb);
      oobx  = (ea && oa) || (eb && ob);
      @(posedge clk);
      if (ea && wa && !oa) mem[aa] = DW'(da);
      if (eb && wb && !ob && !bdrop) mem[ab] = DW'(db);
      exp2a = last2a;
      exp2b = last2b;
      if (ea) begin last1a = ra1; last2a = ra2; end
      if (eb) begin last1b = rb1; last2b = rb2; end
      #1;
      chk("doa_wf", doa1, last1a);
      chk("dob_wf", dob1, last1b);
      chk("doa_rf_reg", doa2, exp2a);
      chk("dob_rf_reg", dob2, exp2b);
      chk("collision_wf", coll1, coll);
      chk("collision_rf", coll2, coll);
      chk("oob_wf", oob1, oobx);
      chk("oob_rf", oob2, oobx);
   endtask

   // Called at #1 after the release edge region; counts CLEAR cycles while
   // hammering both ports with accesses that must all be ignored.
   task automatic run_clear(input string tag);
      int n = 0;
      int bad = 0;
      @(posedge clk); #1;
      while (busy1 === 1'b1 && n < 3000) begin
         n++;
         if (doa1 !== '0 || dob1 !== '0 || doa2 !== '0 || dob2 !== '0 ||
             coll1 !== 1'b0 || coll2 !== 1'b0 || oob1 !== 1'b0 || oob2 !== 1'b0 ||
             busy2 !== 1'b1) bad++;
         ena = 1'b1; enb = 1'b1; wea = 1'b1; web = 1'b1;
         addra = (n % 2) ? AW'(2400) : AW'(2);
         addrb = addra;
         dia = 2'b11; dib = 2'b01;
         @(posedge clk); #1;
      end
      drive_idle();
      chk(tag, n, DEPTH);
      chk({tag, "_quiet"}, bad, 0);
      model_cleared();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      drive_idle();
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_doa", doa1, 0);
      chk("rst_dob", dob1, 0);
      chk("rst_doa_reg", doa2, 0);
      chk("rst_dob_reg", dob2, 0);
      chk("rst_busy", busy1, 1);
      chk("rst_coll", coll1, 0);
      chk("rst_oob", oob2, 0);

      // abort a clear part-way through
      rst_n = 1'b1;
      @(posedge clk);
      repeat (1000) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy1, 1);
      chk("midrst_busy_rf", busy2, 1);
      chk("midrst_doa", doa1, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_clear("clear_len_after_abort");

      step(1, 0, 0, 0, 2395, 0, 0, 0);
      chk("clear_top_word", doa1, 0);

      // basic latency
      step(1, 0, 1, 0, 5, 0, 2'b10, 0);
      step(0, 1, 0, 0, 0, 5, 0, 0);
      chk("basic_lat1", dob1, 2'b10);
      chk("basic_lat2_early", dob2, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("basic_lat2", dob2, 2'b10);
      chk("basic_hold", dob1, 2'b10);

      // same-address double write
      step(1, 1, 1, 1, 7, 7, 2'b01, 2'b11);
      chk("dbl_coll", coll1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("dbl_coll_end", coll1, 0);
      step(1, 0, 0, 0, 7, 0, 0, 0);
      chk("dbl_a_wins", doa1, 2'b01);

      // read-during-write rules
      step(1, 1, 1, 0, 9, 9, 2'b11, 0);
      chk("rdw_wf_own", doa1, 2'b11);
      chk("rdw_cross", dob1, 2'b00);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rdw_rf_own", doa2, 2'b00);
      chk("rdw_cross_rf", dob2, 2'b00);

      // out of range
      step(1, 0, 1, 0, 2400, 0, 2'b10, 0);
      chk("oob_wr_pulse", oob1, 1);
      step(1, 0, 0, 0, 2400, 0, 0, 0);
      chk("oob_rd_zero", doa1, 0);
      chk("oob_rd_pulse", oob1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("oob_pulse_end", oob1, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         int aa, ab;
         aa = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 15))
                                         : int'($urandom_range(DEPTH - 4, DEPTH + 4));
         ab = ($urandom_range(0, 1) == 0) ? aa
            : (($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 15))
                                          : int'($urandom_range(DEPTH - 4, DEPTH + 4)));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              aa, ab, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // contents survive nothing but a fresh clear
      step(1, 0, 1, 0, 2395, 0, 2'b11, 0);
      step(1, 0, 0, 0, 2395, 0, 0, 0);
      chk("top_word_written", doa1, 2'b11);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      run_clear("clear_len_full");
      step(1, 0, 0, 0, 2395, 0, 0, 0);
      chk("top_word_recleared", doa1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
